id_exe_stage: RTL and testbench

- ID/EX pipeline stage of the 5-stage MIPS core. Sits directly downstream of the ID-stage forwarding unit.
- Consumes its hd_rs/hd_rt select codes and resolves the final rs/rt operand values from the register file or a forwarding source.
- Detects load-use hazards, issues a one-cycle stall and bubble, and registers the decoded instruction into the EX stage.
- Honours branch flush and downstream hold.

---
 rtl/id_exe_stage.sv | 158 +++++++++++++++
 tb/tb_id_exe_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core: resolves forwarded operands,
// inserts a one-cycle bubble on load-use hazards, and honours flush and hold.
module id_exe_stage #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic [4:0]       rd_id,
    input  logic             uses_rs,
    input  logic             uses_rt,
    input  logic             id_regwrite,
    input  logic [1:0]       id_memread,
    input  logic             id_memwrite,
    input  logic [3:0]       id_aluop,
    input  logic [DW-1:0]    id_imm,
    input  logic [DW-1:0]    rf_rs_data,
    input  logic [DW-1:0]    rf_rt_data,
    input  logic [1:0]       hd_rs,
    input  logic [1:0]       hd_rt,
    input  logic [DW-1:0]    exe_alu_result,
    input  logic [DW-1:0]    mem_alu_result,
    input  logic [DW-1:0]    mem_load_data,
    input  logic [4:0]       rd_exe,
    input  logic             RegWrite_exe,
    input  logic [1:0]       MemRead_exe,
    input  logic             flush,
    input  logic             hold,
    output logic             stall_id,
    output logic             ex_valid,
    output logic [31:0]      ex_pc,
    output logic [DW-1:0]    ex_rs_val,
    output logic [DW-1:0]    ex_rt_val,
    output logic [4:0]       ex_rd,
    output logic             ex_regwrite,
    output logic [1:0]       ex_memread,
    output logic             ex_memwrite,
    output logic [3:0]       ex_aluop,
    output logic [DW-1:0]    ex_imm,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_STALL1 = 1'b1;

    logic [0:0]       r_state;
    logic             r_ex_valid;
    logic [31:0]      r_ex_pc;
    logic [DW-1:0]    r_ex_rs_val;
    logic [DW-1:0]    r_ex_rt_val;
    logic [4:0]       r_ex_rd;
    logic             r_ex_regwrite;
    logic [1:0]       r_ex_memread;
    logic             r_ex_memwrite;
    logic [3:0]       r_ex_aluop;
    logic [DW-1:0]    r_ex_imm;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic [DW-1:0]    w_rs_val;
    logic [DW-1:0]    w_rt_val;
    logic             w_luh;
    logic             w_luh_run;

    function automatic logic [DW-1:0] sel_operand(
        input logic [4:0]    r,
        input logic [1:0]    sel,
        input logic [DW-1:0] rf,
        input logic [DW-1:0] exe,
        input logic [DW-1:0] mem,
        input logic [DW-1:0] ld
    );
        logic [DW-1:0] v;
        case (sel)
            2'b00:   v = rf;
            2'b01:   v = exe;
            2'b10:   v = mem;
            default: v = ld;
        endcase
        return (r == 5'd0) ? '0 : v;
    endfunction

    always_comb begin
        w_rs_val = sel_operand(rs_id, hd_rs, rf_rs_data, exe_alu_result, mem_alu_result, mem_load_data);
        w_rt_val = sel_operand(rt_id, hd_rt, rf_rt_data, exe_alu_result, mem_alu_result, mem_load_data);
    end

    // In STALL1 the producing load has moved to MEM, so the hazard is already resolved.
    assign w_luh = id_valid && RegWrite_exe && (MemRead_exe != 2'b00) && (rd_exe != 5'd0) &&
                   ((uses_rs && (rs_id == rd_exe)) || (uses_rt && (rt_id == rd_exe)));
    assign w_luh_run = w_luh && (r_state == ST_RUN);

    assign stall_id = rst_n && !flush && (w_luh_run || hold);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= '0;
            r_ex_rs_val   <= '0;
            r_ex_rt_val   <= '0;
            r_ex_rd       <= '0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= '0;
            r_ex_memwrite <= 1'b0;
            r_ex_aluop    <= '0;
            r_ex_imm      <= '0;
            r_bubble_cnt  <= '0;
        end else if (hold) begin
            if (flush) begin
                r_state <= ST_RUN;
            end
        end else if (flush || w_luh_run) begin
            r_state       <= flush ? ST_RUN : ST_STALL1;
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= '0;
            r_ex_rs_val   <= '0;
            r_ex_rt_val   <= '0;
            r_ex_rd       <= '0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= '0;
            r_ex_memwrite <= 1'b0;
            r_ex_aluop    <= '0;
            r_ex_imm      <= '0;
            if (!flush && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end else begin
            r_state       <= ST_RUN;
            r_ex_valid    <= id_valid;
            r_ex_pc       <= id_pc;
            r_ex_rs_val   <= w_rs_val;
            r_ex_rt_val   <= w_rt_val;
            r_ex_rd       <= rd_id;
            r_ex_regwrite <= id_regwrite;
            r_ex_memread  <= id_memread;
            r_ex_memwrite <= id_memwrite;
            r_ex_aluop    <= id_aluop;
            r_ex_imm      <= id_imm;
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_pc       = r_ex_pc;
    assign ex_rs_val   = r_ex_rs_val;
    assign ex_rt_val   = r_ex_rt_val;
    assign ex_rd       = r_ex_rd;
    assign ex_regwrite = r_ex_regwrite;
    assign ex_memread  = r_ex_memread;
    assign ex_memwrite = r_ex_memwrite;
    assign ex_aluop    = r_ex_aluop;
    assign ex_imm      = r_ex_imm;
    assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_id_exe_stage.sv
// Directed-vector bench for id_exe_stage with a cycle-level reference model.
module tb_id_exe_stage;

    localparam int DW    = 32;
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [31:0]      id_pc;
    logic [4:0]       rs_id, rt_id, rd_id;
    logic             uses_rs, uses_rt;
    logic             id_regwrite;
    logic [1:0]       id_memread;
    logic             id_memwrite;
    logic [3:0]       id_aluop;
    logic [DW-1:0]    id_imm;
    logic [DW-1:0]    rf_rs_data, rf_rt_data;
    logic [1:0]       hd_rs, hd_rt;
    logic [DW-1:0]    exe_alu_result, mem_alu_result, mem_load_data;
    logic [4:0]       rd_exe;
    logic             RegWrite_exe;
    logic [1:0]       MemRead_exe;
    logic             flush, hold;
    logic             stall_id;
    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic [DW-1:0]    ex_rs_val, ex_rt_val;
    logic [4:0]       ex_rd;
    logic             ex_regwrite;
    logic [1:0]       ex_memread;
    logic             ex_memwrite;
    logic [3:0]       ex_aluop;
    logic [DW-1:0]    ex_imm;
    logic [CNT_W-1:0] bubble_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 0;

    id_exe_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id), .uses_rs(uses_rs), .uses_rt(uses_rt),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_aluop(id_aluop), .id_imm(id_imm), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
        .hd_rs(hd_rs), .hd_rt(hd_rt), .exe_alu_result(exe_alu_result),
        .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data), .rd_exe(rd_exe),
        .RegWrite_exe(RegWrite_exe), .MemRead_exe(MemRead_exe), .flush(flush), .hold(hold),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_val(ex_rs_val),
        .ex_rt_val(ex_rt_val), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_aluop(ex_aluop),
        .ex_imm(ex_imm), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the EX register contents as the pipeline rules describe them.
    logic             m_valid, m_regwrite, m_memwrite;
    logic [31:0]      m_pc, m_rs, m_rt, m_imm;
    logic [4:0]       m_rd;
    logic [1:0]       m_memread;
    logic [3:0]       m_aluop;
    int               m_cnt;
    bit               m_after_bubble;

    function automatic logic [31:0] pick(input logic [4:0] r, input logic [1:0] sel, input logic [31:0] rf);
        if (r == 0) return 32'd0;
        if (sel == 2'd0) return rf;
        if (sel == 2'd1) return exe_alu_result;
        if (sel == 2'd2) return mem_alu_result;
        return mem_load_data;
    endfunction

    function automatic bit hazard();
        bit hit_rs, hit_rt;
        hit_rs = uses_rs && rs_id == rd_exe;
        hit_rt = uses_rt && rt_id == rd_exe;
        return id_valid && RegWrite_exe && MemRead_exe != 0 && rd_exe != 0 && (hit_rs || hit_rt)
               && !m_after_bubble;
    endfunction

    task automatic model_clear();
        {m_valid, m_regwrite, m_memwrite, m_pc, m_rs, m_rt, m_imm, m_rd, m_memread, m_aluop} = '0;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            model_clear();
            m_cnt = 0;
            m_after_bubble = 0;
        end else if (hold) begin
            if (flush) m_after_bubble = 0;
        end else if (flush) begin
            model_clear();
            m_after_bubble = 0;
        end else if (hazard()) begin
            model_clear();
            if (m_cnt < int'(CNT_MAX)) m_cnt = m_cnt + 1;
            m_after_bubble = 1;
        end else begin
            m_valid = id_valid;   m_pc = id_pc;        m_rd = rd_id;
            m_rs = pick(rs_id, hd_rs, rf_rs_data);
            m_rt = pick(rt_id, hd_rt, rf_rt_data);
            m_regwrite = id_regwrite; m_memread = id_memread; m_memwrite = id_memwrite;
            m_aluop = id_aluop;   m_imm = id_imm;
            m_after_bubble = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_stall_id", {31'd0, stall_id}, {31'd0, rst_n && !flush && (hold || hazard())});
            chk("m_ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
            chk("m_ex_pc", ex_pc, m_pc);
            chk("m_ex_rs_val", ex_rs_val, m_rs);
            chk("m_ex_rt_val", ex_rt_val, m_rt);
            chk("m_ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
            chk("m_ex_ctrl", {24'd0, ex_regwrite, ex_memread, ex_memwrite, ex_aluop},
                {24'd0, m_regwrite, m_memread, m_memwrite, m_aluop});
            chk("m_ex_imm", ex_imm, m_imm);
            chk("m_bubble_cnt", {{(32-CNT_W){1'b0}}, bubble_cnt}, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_pc = 0; rs_id = 0; rt_id = 0; rd_id = 0; uses_rs = 0; uses_rt = 0;
        id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_aluop = 0; id_imm = 0;
        rf_rs_data = 0; rf_rt_data = 0; hd_rs = 0; hd_rt = 0;
        exe_alu_result = 0; mem_alu_result = 0; mem_load_data = 0;
        rd_exe = 0; RegWrite_exe = 0; MemRead_exe = 0; flush = 0; hold = 0;
    endtask

    task automatic load_use_setup();
        id_valid = 1; id_pc = 32'h300; rs_id = 5'd8; rt_id = 5'd2; rd_id = 5'd9;
        uses_rs = 1; uses_rt = 1; hd_rs = 2'b00; hd_rt = 2'b00;
        rd_exe = 5'd8; RegWrite_exe = 1; MemRead_exe = 2'b01;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        tick(); tick();
        cmp_en = 1;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_bubble_cnt", {26'd0, bubble_cnt}, 32'd0);
        chk("rst_stall_id", {31'd0, stall_id}, 32'd0);
        rst_n = 1;

        // Independent instruction
        id_valid = 1; id_pc = 32'h100; rs_id = 5'd1; rt_id = 5'd2; rd_id = 5'd3;
        uses_rs = 1; uses_rt = 1; id_regwrite = 1; id_aluop = 4'd2; id_imm = 32'h1234;
        rf_rs_data = 32'd5; rf_rt_data = 32'd7;
        #1 chk("indep_stall", {31'd0, stall_id}, 32'd0);
        tick();
        chk("indep_rs", ex_rs_val, 32'd5);
        chk("indep_rt", ex_rt_val, 32'd7);
        chk("indep_valid", {31'd0, ex_valid}, 32'd1);
        chk("indep_pc", ex_pc, 32'h100);

        // Forwarding, then the same with rs = $0
        hd_rs = 2'b01; exe_alu_result = 32'h10; hd_rt = 2'b11; mem_load_data = 32'hAB;
        mem_alu_result = 32'h99;
        tick();
        chk("fwd_rs", ex_rs_val, 32'h10);
        chk("fwd_rt", ex_rt_val, 32'hAB);
        rs_id = 5'd0;
        tick();
        chk("fwd_r0", ex_rs_val, 32'd0);
        hd_rs = 2'b10; rs_id = 5'd4;
        tick();
        chk("fwd_mem_alu", ex_rs_val, 32'h99);

        // Load-use: one stall, bubble, then forwarded load data
        idle_inputs();
        load_use_setup();
        #1 chk("lu_stall", {31'd0, stall_id}, 32'd1);
        tick();
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        chk("lu_cnt", {26'd0, bubble_cnt}, 32'd1);
        hd_rs = 2'b11; mem_load_data = 32'h55;
        #1 chk("lu_stall1_nostall", {31'd0, stall_id}, 32'd0);
        tick();
        chk("lu_rs", ex_rs_val, 32'h55);
        chk("lu_valid", {31'd0, ex_valid}, 32'd1);

        // No hazard when rs is not read, or when rd_exe is $0
        idle_inputs();
        load_use_setup();
        uses_rs = 0;
        #1 chk("nouse_stall", {31'd0, stall_id}, 32'd0);
        tick();
        chk("nouse_cnt", {26'd0, bubble_cnt}, 32'd1);
        uses_rs = 1; rs_id = 5'd0; rd_exe = 5'd0;
        #1 chk("r0_stall", {31'd0, stall_id}, 32'd0);
        tick();
        chk("r0_valid", {31'd0, ex_valid}, 32'd1);

        // Flush wins over load-use
        load_use_setup();
        flush = 1;
        #1 chk("flush_stall", {31'd0, stall_id}, 32'd0);
        tick();
        chk("flush_bubble", {31'd0, ex_valid}, 32'd0);
        chk("flush_cnt", {26'd0, bubble_cnt}, 32'd1);

        // Hold freezes the EX register for 3 cycles
        idle_inputs();
        id_valid = 1; id_pc = 32'h200; rs_id = 5'd5; rf_rs_data = 32'hCAFE; rd_id = 5'd6;
        tick();
        hold = 1; id_pc = 32'h204; rf_rs_data = 32'hBEEF;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_stall", {31'd0, stall_id}, 32'd1);
            tick();
            chk("hold_pc", ex_pc, 32'h200);
            chk("hold_rs", ex_rs_val, 32'hCAFE);
        end
        hold = 0;

        // Saturation: CNT_MAX+2 load-use events in total
        idle_inputs();
        load_use_setup();
        for (int i = 0; i < int'(CNT_MAX) + 1; i++) begin
            tick();
            tick();
        end
        chk("sat_cnt", {26'd0, bubble_cnt}, int'(CNT_MAX));

        // Reset asserted in STALL1 discards the bubble and returns to RUN
        tick();
        rst_n = 0;
        #1 chk("rst_mid_stall", {31'd0, stall_id}, 32'd0);
        tick();
        chk("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_mid_pc", ex_pc, 32'd0);
        chk("rst_mid_cnt", {26'd0, bubble_cnt}, 32'd0);
        rst_n = 1;
        #1 chk("post_rst_stall", {31'd0, stall_id}, 32'd1);
        tick();
        chk("post_rst_cnt", {26'd0, bubble_cnt}, 32'd1);

        idle_inputs();
        tick();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
